// File: rtl/led_pwm_if.sv
// Avalon-MM slave bus for the LED PWM driver: 2-bit word address, zero-wait
// writes, combinational readdata.
interface led_pwm_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata
  );

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata
  );
endinterface

// File: rtl/led_pwm_driver.sv
// LED PWM driver: sits behind the LED PIO and applies global PWM dimming,
// optional blinking and polarity inversion to the 8-bit LED pattern.
// Out of reset it behaves as a 1-cycle registered pass-through.
module led_pwm_driver #(
  parameter int unsigned PRESCALE = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  led_pwm_if.slave   bus,
  input  logic [7:0] led_in,
  output logic [7:0] led_out
);

  localparam logic [15:0] PRE_LAST = 16'(PRESCALE - 1);

  logic [15:0] pre_cnt_q, pre_cnt_d;
  logic [7:0]  pwm_cnt_q, pwm_cnt_d;
  logic [15:0] frame_cnt_q, frame_cnt_d;
  logic        phase_q, phase_d;
  logic [2:0]  ctrl_q, ctrl_d;
  logic [7:0]  shadow_q, shadow_d;
  logic [7:0]  duty_q, duty_d;
  logic [15:0] bp_q, bp_d;
  logic [7:0]  led_out_q, led_out_d;

  logic tick, frame_end, wr_en, pwm_on, lit;
  logic unused_wd;

  assign unused_wd = ^bus.writedata[31:16];

  // Prescaler and PWM position counters; frame_end marks the last clock of a frame.
  always_comb begin
    tick      = (pre_cnt_q == PRE_LAST);
    frame_end = tick && (pwm_cnt_q == 8'hFF);
    pre_cnt_d = tick ? 16'd0 : pre_cnt_q + 16'd1;
    pwm_cnt_d = tick ? pwm_cnt_q + 8'd1 : pwm_cnt_q;
  end

  // Register writes, frame-start duty load and blink phase tracking.
  always_comb begin
    wr_en       = bus.chipselect && !bus.write_n;
    ctrl_d      = ctrl_q;
    shadow_d    = shadow_q;
    bp_d        = bp_q;
    duty_d      = duty_q;
    frame_cnt_d = frame_cnt_q;
    phase_d     = phase_q;

    if (wr_en) begin
      case (bus.address)
        2'd0:    ctrl_d   = bus.writedata[2:0];
        2'd1:    shadow_d = bus.writedata[7:0];
        2'd2:    bp_d     = bus.writedata[15:0];
        default: ;
      endcase
    end

    // Loading from shadow_d lets a BRIGHTNESS write in the frame_end cycle
    // take effect at the very next frame start.
    if (frame_end) begin
      duty_d = shadow_d;
      if (bp_q != 16'd0) begin
        if (frame_cnt_q == bp_q - 16'd1) begin
          frame_cnt_d = 16'd0;
          phase_d     = ~phase_q;
        end else begin
          frame_cnt_d = frame_cnt_q + 16'd1;
        end
      end
    end

    // Register writes override the frame_end update of the blink state.
    if (wr_en && (bus.address == 2'd0) && !bus.writedata[1]) begin
      phase_d = 1'b0;
    end
    if (wr_en && (bus.address == 2'd2)) begin
      frame_cnt_d = 16'd0;
      phase_d     = 1'b0;
    end
  end

  // LED output function; duty 0xFF is fully on rather than 255/256.
  always_comb begin
    pwm_on    = (duty_q == 8'hFF) || (pwm_cnt_q < duty_q);
    lit       = ctrl_q[0] & pwm_on & ~(ctrl_q[1] & phase_q);
    led_out_d = {8{ctrl_q[2]}} ^ (led_in & {8{lit}});
  end

  // Combinational read mux, zero when not selected.
  always_comb begin
    bus.readdata = 32'd0;
    if (bus.chipselect) begin
      case (bus.address)
        2'd0:    bus.readdata = {29'd0, ctrl_q};
        2'd1:    bus.readdata = {24'd0, shadow_q};
        2'd2:    bus.readdata = {16'd0, bp_q};
        default: bus.readdata = {duty_q, 7'd0, phase_q, frame_cnt_q};
      endcase
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pre_cnt_q   <= 16'd0;
      pwm_cnt_q   <= 8'd0;
      frame_cnt_q <= 16'd0;
      phase_q     <= 1'b0;
      ctrl_q      <= 3'b001;
      shadow_q    <= 8'hFF;
      duty_q      <= 8'hFF;
      bp_q        <= 16'd0;
      led_out_q   <= 8'h00;
    end else begin
      pre_cnt_q   <= pre_cnt_d;
      pwm_cnt_q   <= pwm_cnt_d;
      frame_cnt_q <= frame_cnt_d;
      phase_q     <= phase_d;
      ctrl_q      <= ctrl_d;
      shadow_q    <= shadow_d;
      duty_q      <= duty_d;
      bp_q        <= bp_d;
      led_out_q   <= led_out_d;
    end
  end

  assign led_out = led_out_q;

endmodule

// File: tb/tb_led_pwm_driver.sv
// Self-checking bench for led_pwm_driver with a behavioural reference model.
module tb_led_pwm_driver;
  localparam int P     = 1;
  localparam int FRAME = 256 * P;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] led_in = 8'h00;
  logic [7:0] led_out;

  led_pwm_if bus ();

  led_pwm_driver #(.PRESCALE(P)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus),
    .led_in  (led_in),
    .led_out (led_out)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference model: cycle index since reset, frame position by arithmetic.
  int unsigned m_cyc, m_fc;
  logic [2:0]  m_ctrl;
  logic [7:0]  m_shadow, m_duty, exp_led;
  logic [15:0] m_bp;
  logic        m_phase;
  int unsigned m_pos;
  logic [7:0]  m_level;
  logic        m_lit, m_wr;

  initial begin
    forever begin
      @(posedge clk or negedge reset_n);
      if (!reset_n) begin
        m_cyc = 0; m_fc = 0; m_ctrl = 3'b001; m_shadow = 8'hFF; m_duty = 8'hFF;
        m_bp = 16'd0; m_phase = 1'b0; exp_led = 8'h00;
      end else begin
        m_pos   = m_cyc % FRAME;
        m_level = 8'(m_pos / P);
        m_lit   = m_ctrl[0] && ((m_duty == 8'hFF) || (m_level < m_duty)) && !(m_ctrl[1] && m_phase);
        exp_led = {8{m_ctrl[2]}} ^ (led_in & {8{m_lit}});
        m_wr    = bus.chipselect && !bus.write_n;
        if (m_wr && bus.address == 2'd1) m_shadow = bus.writedata[7:0];
        if (m_pos == FRAME - 1) begin
          m_duty = m_shadow;
          if (m_bp != 0) begin
            m_fc++;
            if (m_fc == m_bp) begin m_fc = 0; m_phase = !m_phase; end
          end
        end
        if (m_wr && bus.address == 2'd0) begin
          m_ctrl = bus.writedata[2:0];
          if (!bus.writedata[1]) m_phase = 1'b0;
        end
        if (m_wr && bus.address == 2'd2) begin
          m_bp = bus.writedata[15:0]; m_fc = 0; m_phase = 1'b0;
        end
        m_cyc++;
      end
    end
  end

  function automatic logic [31:0] exp_status();
    return {m_duty, 7'd0, m_phase, m_fc[15:0]};
  endfunction

  task automatic bus_idle();
    bus.chipselect = 1'b1; bus.write_n = 1'b1; bus.address = 2'd3; bus.writedata = 32'd0;
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    bus.chipselect = 1'b1; bus.write_n = 1'b0; bus.address = a; bus.writedata = d;
    @(negedge clk);
    bus_idle();
  endtask

  task automatic test_reset();
    logic [31:0] exp_rd [4];
    exp_rd[0] = 32'h1; exp_rd[1] = 32'hFF; exp_rd[2] = 32'h0; exp_rd[3] = 32'hFF00_0000;
    bus.chipselect = 1'b0; bus.write_n = 1'b1; bus.address = 2'd0; bus.writedata = 32'd0;
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (led_out !== 8'h00) begin failures++; $display("FAIL reset_led got=%h exp=00", led_out); end
    checks++;
    if (bus.readdata !== 32'd0) begin failures++; $display("FAIL reset_rd got=%h exp=0", bus.readdata); end
    reset_n = 1'b1;
    led_in  = 8'hA5;
    @(negedge clk);
    checks++;
    if (led_out !== 8'hA5) begin failures++; $display("FAIL passthru got=%h exp=a5", led_out); end
    for (int a = 0; a < 4; a++) begin
      bus.chipselect = 1'b1; bus.address = 2'(a);
      #1;
      checks++;
      if (bus.readdata !== exp_rd[a]) begin
        failures++; $display("FAIL reset_reg a=%0d got=%h exp=%h", a, bus.readdata, exp_rd[a]);
      end
    end
    bus_idle();
  endtask

  task automatic test_pwm_duty();
    bit found;
    led_in = 8'hFF;
    bus_write(2'd1, 32'h40);
    found = 0;
    for (int i = 0; i < 600 && !found; i++) begin
      @(negedge clk);
      checks++;
      if (led_out !== exp_led) begin failures++; $display("FAIL duty_wait got=%h exp=%h", led_out, exp_led); end
      if (m_duty == 8'h40) found = 1;
    end
    checks++;
    if (!found) begin failures++; $display("FAIL duty_load_timeout got=0 exp=1"); end
    checks++;
    if (bus.readdata[31:24] !== 8'h40) begin failures++; $display("FAIL duty_status got=%h exp=40", bus.readdata[31:24]); end
    for (int i = 0; i < 2 * FRAME; i++) begin
      @(negedge clk);
      checks++;
      if (led_out !== ((i % FRAME) < 64 ? 8'hFF : 8'h00)) begin
        failures++; $display("FAIL duty_40 i=%0d got=%h exp=%h", i, led_out, ((i % FRAME) < 64 ? 8'hFF : 8'h00));
      end
    end
    bus_write(2'd1, 32'h00);
    for (int i = 0; i < 600; i++) begin
      @(negedge clk);
      checks++;
      if (led_out !== exp_led) begin failures++; $display("FAIL duty0_model got=%h exp=%h", led_out, exp_led); end
      if (i >= 300) begin
        checks++;
        if (led_out !== 8'h00) begin failures++; $display("FAIL duty0_dark got=%h exp=00", led_out); end
      end
      led_in = 8'($urandom);
    end
  endtask

  task automatic test_blink();
    int last_t, toggles;
    logic prev_ph;
    bit found;
    bus_write(2'd1, 32'hFF);
    repeat (FRAME + 2) @(negedge clk);
    led_in = 8'h0F;
    bus_write(2'd2, 32'd2);
    bus_write(2'd0, 32'h3);
    last_t = -1; toggles = 0; prev_ph = 1'b0;
    for (int i = 0; i < 2200; i++) begin
      @(negedge clk);
      checks++;
      if (led_out !== exp_led) begin failures++; $display("FAIL blink_led i=%0d got=%h exp=%h", i, led_out, exp_led); end
      checks++;
      if (bus.readdata !== exp_status()) begin failures++; $display("FAIL blink_status got=%h exp=%h", bus.readdata, exp_status()); end
      if (bus.readdata[16] !== prev_ph) begin
        if (last_t >= 0) begin
          checks++;
          if (i - last_t != 2 * FRAME) begin failures++; $display("FAIL blink_period got=%0d exp=%0d", i - last_t, 2 * FRAME); end
        end
        last_t = i; prev_ph = bus.readdata[16]; toggles++;
      end
    end
    checks++;
    if (toggles < 3) begin failures++; $display("FAIL blink_toggles got=%0d exp>=3", toggles); end
    found = 0;
    for (int i = 0; i < 1200 && !found; i++) begin
      @(negedge clk);
      if (m_phase && m_ctrl[1]) found = 1;
    end
    checks++;
    if (!found) begin failures++; $display("FAIL blink_dark_timeout got=0 exp=1"); end
    bus.chipselect = 1'b1; bus.write_n = 1'b0; bus.address = 2'd0; bus.writedata = 32'h1;
    @(negedge clk);
    bus_idle();
    checks++;
    if (led_out !== 8'h00) begin failures++; $display("FAIL blink_still_dark got=%h exp=00", led_out); end
    @(negedge clk);
    checks++;
    if (led_out !== 8'h0F) begin failures++; $display("FAIL blink_clear got=%h exp=0f", led_out); end
  endtask

  task automatic test_invert();
    bus_write(2'd0, 32'h4);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      checks++;
      if (led_out !== 8'hFF) begin failures++; $display("FAIL invert_off got=%h exp=ff", led_out); end
      led_in = 8'($urandom);
    end
    led_in = 8'h81;
    bus_write(2'd0, 32'h5);
    @(negedge clk);
    checks++;
    if (led_out !== 8'h7E) begin failures++; $display("FAIL invert_on got=%h exp=7e", led_out); end
    for (int k = 0; k < 8; k++) begin
      bus_write(2'd0, 32'($urandom_range(0, 7)));
      for (int i = 0; i < 40; i++) begin
        @(negedge clk);
        checks++;
        if (led_out !== exp_led) begin failures++; $display("FAIL ctrl_rand got=%h exp=%h", led_out, exp_led); end
        led_in = 8'($urandom);
      end
    end
  endtask

  task automatic test_midframe();
    bit found;
    bus_write(2'd2, 32'd0);
    bus_write(2'd0, 32'h1);
    bus_write(2'd1, 32'hFF);
    led_in = 8'hFF;
    found = 0;
    for (int i = 0; i < 800 && !found; i++) begin
      @(negedge clk);
      if (m_duty == 8'hFF && (m_cyc % FRAME) == 100) found = 1;
    end
    checks++;
    if (!found) begin failures++; $display("FAIL mid_sync_timeout got=0 exp=1"); end
    bus.chipselect = 1'b1; bus.write_n = 1'b0; bus.address = 2'd1; bus.writedata = 32'h10;
    for (int k = 1; k <= 180; k++) begin
      @(negedge clk);
      bus_idle();
      #1;
      checks++;
      if (bus.readdata[31:24] !== (k >= 156 ? 8'h10 : 8'hFF)) begin
        failures++; $display("FAIL mid_status k=%0d got=%h exp=%h", k, bus.readdata[31:24], (k >= 156 ? 8'h10 : 8'hFF));
      end
      checks++;
      if (led_out !== (k <= 172 ? 8'hFF : 8'h00)) begin
        failures++; $display("FAIL mid_led k=%0d got=%h exp=%h", k, led_out, (k <= 172 ? 8'hFF : 8'h00));
      end
    end
  endtask

  task automatic test_back_to_back();
    bit found;
    found = 0;
    for (int i = 0; i < 600 && !found; i++) begin
      @(negedge clk);
      if ((m_cyc % FRAME) == FRAME - 1) found = 1;
    end
    bus.chipselect = 1'b1; bus.write_n = 1'b0; bus.address = 2'd1; bus.writedata = 32'h80;
    @(negedge clk);
    bus_idle();
    #1;
    checks++;
    if (!found || bus.readdata[31:24] !== 8'h80) begin
      failures++; $display("FAIL fe_bright got=%h exp=80 sync=%0d", bus.readdata[31:24], found);
    end
    bus_write(2'd2, 32'd1);
    found = 0;
    for (int i = 0; i < 1200 && !found; i++) begin
      @(negedge clk);
      if (!m_phase && m_cyc > 300 && (m_cyc % FRAME) == FRAME - 1) found = 1;
    end
    bus.chipselect = 1'b1; bus.write_n = 1'b0; bus.address = 2'd2; bus.writedata = 32'd1;
    @(negedge clk);
    bus_idle();
    #1;
    checks++;
    if (!found || bus.readdata[16:0] !== 17'd0) begin
      failures++; $display("FAIL fe_blink got=%h exp=0 sync=%0d", bus.readdata[16:0], found);
    end
    checks++;
    if (bus.readdata !== exp_status()) begin failures++; $display("FAIL fe_model got=%h exp=%h", bus.readdata, exp_status()); end
  endtask

  task automatic test_reset_midblink();
    bit found;
    logic [31:0] exp_rd [4];
    exp_rd[0] = 32'h1; exp_rd[1] = 32'hFF; exp_rd[2] = 32'h0; exp_rd[3] = 32'hFF00_0000;
    bus_write(2'd2, 32'd1);
    bus_write(2'd0, 32'h7);
    found = 0;
    for (int i = 0; i < 1200 && !found; i++) begin
      @(negedge clk);
      led_in = 8'($urandom);
      if (m_phase) found = 1;
    end
    @(negedge clk);
    checks++;
    if (!found || led_out !== 8'hFF) begin failures++; $display("FAIL rst_pre got=%h exp=ff sync=%0d", led_out, found); end
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (led_out !== 8'h00) begin failures++; $display("FAIL rst_async got=%h exp=00", led_out); end
    @(negedge clk);
    reset_n = 1'b1;
    for (int a = 0; a < 4; a++) begin
      bus.address = 2'(a);
      #1;
      checks++;
      if (bus.readdata !== exp_rd[a]) begin
        failures++; $display("FAIL rst_reg a=%0d got=%h exp=%h", a, bus.readdata, exp_rd[a]);
      end
    end
    bus_idle();
  endtask

  initial begin
    test_reset();
    test_pwm_duty();
    test_blink();
    test_invert();
    test_midframe();
    test_back_to_back();
    test_reset_midblink();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
